fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
- Single-clock, parametrised FIFO; next generation of the team's buffer block.
- Configurable data width, depth and almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags and a read-data-valid strobe.
- Sits between a producer and a consumer in the same clock domain; used as the standard elastic buffer in datapaths.

Parameters:
- WIDTH, 8, data bits per entry.
- DEPTH, 64, number of entries; power of two, minimum 2.
- AF_LEVEL, 56, buf_almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 8, buf_almost_empty asserts when count <= AE_LEVEL.
- Elaboration check: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH. Violation is a fatal error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- buf_in  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- err_clr  in  1  clears the sticky error flags.
- buf_out  out  WIDTH  registered read data.
- rd_valid  out  1  buf_out updated this cycle.
- buf_empty  out  1  count == 0.
- buf_full  out  1  count == DEPTH.
- buf_almost_empty  out  1  count <= AE_LEVEL.
- buf_almost_full  out  1  count >= AF_LEVEL.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- fifo_counter  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n; every register clears immediately when rst_n goes low.
- Reset values:
  - fifo_counter=0, wr_ptr=0, rd_ptr=0, buf_out=0, rd_valid=0, overflow=0, underflow=0.
  - Resulting flags: buf_empty=1, buf_almost_empty=1, buf_full=0, buf_almost_full=0.
  - Memory contents are not reset.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en & !buf_full.
  - rd_acc = rd_en & !buf_empty.
- Pointers:
  - Both are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Each increments by 1 on its accept.
- Counter update:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both: unchanged.
  - Neither: hold.
  - The counter never exceeds DEPTH and never goes below 0.
- Simultaneous read and write:
  - At full: read accepted, write rejected; the count becomes DEPTH-1 and overflow sets.
  - At empty: write accepted, read rejected; the count becomes 1 and underflow sets.
  - Otherwise both are accepted.
- Write path: on wr_acc, mem[wr_ptr] <= buf_in at the edge.
- Read path:
  - On rd_acc, buf_out <= mem[rd_ptr] at the edge and rd_valid=1 for exactly that following cycle.
  - Latency is 1 clock from the rd_en sample.
  - Without rd_acc, buf_out holds and rd_valid=0.
- Write-to-read:
  - A word written at edge N is readable by a rd_en sampled at edge N+1 or later.
  - There is no bypass when empty.
- Status flags are combinational decodes of the registered fifo_counter and are glitch-free relative to clk.
- Error flags:
  - overflow sets on wr_en & buf_full; underflow sets on rd_en & buf_empty.
  - Both clear on err_clr.
  - If a set condition and err_clr occur in the same cycle, set wins.
  - A rejected request does not change any other state.
- Reset asserted mid-operation:
  - All state clears immediately; stored data is lost logically.
  - The first cycle after rst_n deassertion behaves as empty.

Optional Feature:
- Macro FIFO_HWM_EN.
- When defined:
  - Adds output port buf_hwm, width $clog2(DEPTH)+1, a high-water mark.
  - Each edge: buf_hwm <= max(buf_hwm, next fifo_counter).
  - Reset value 0; cleared to 0 by err_clr, and a same-cycle update then loads the next count.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg:
  - Function cnt_w(depth) returning $clog2(depth)+1.
  - Localparam helpers for pointer width.
  - Shared parameter-check macro.
- Sub-module fifo_sdp_ram:
  - Simple dual-port RAM, WIDTH x DEPTH.
  - Synchronous write; registered read with a read-enable.
  - Holds the buf_out register so it maps to block RAM.
- Top level holds pointers, counter, flags, error and HWM logic.

Test Plan:
All scenarios use WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=3.
1. Reset, then write 0x01..0x10 -> buf_almost_empty drops after the 4th write, buf_almost_full rises after the 12th, buf_full=1 and fifo_counter=16 after the 16th. Then read 16 -> buf_out returns 0x01..0x10 in order, each with rd_valid one cycle after rd_en.
2. Full FIFO, 17th write of 0xAA -> rejected, overflow=1, fifo_counter=16. Read back -> 0xAA never appears. err_clr -> overflow=0.
3. Empty FIFO, rd_en with wr_en=1 and buf_in=0x55 -> underflow=1, count=1, rd_valid=0. Next rd_en -> buf_out=0x55.
4. Full FIFO, wr_en=rd_en=1 -> count=15, overflow=1. Half-full (8 entries) with both enables for 20 cycles -> count stays 8, data order preserved across pointer wrap.
5. rst_n pulled low asynchronously mid-burst at count=9 -> outputs clear without a clock edge, buf_empty=1. After release, a write of 0x33 then a read returns 0x33.
6. With FIFO_HWM_EN defined: fill to 10, drain to 2 -> buf_hwm=10. err_clr -> buf_hwm=2.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// =============================================================================
// fifo_pkg : shared sizing helpers and the parameter-legality check for fifo_*.
// Rev 1.0
// =============================================================================
`ifndef FIFO_PKG_MACROS
`define FIFO_PKG_MACROS
// Fails elaboration unless DEPTH is a power of two >= 2 and 0 <= AE < AF <= DEPTH.
`define FIFO_PARAM_CHECK(DEPTH_P, AF_P, AE_P) \
  if (((DEPTH_P) < fifo_pkg::FIFO_MIN_DEPTH) || ((((DEPTH_P) & ((DEPTH_P) - 1))) != 0) || \
      ((AE_P) < 0) || ((AE_P) >= (AF_P)) || ((AF_P) > (DEPTH_P))) begin : g_param_fail \
    $fatal(1, "fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL combination"); \
  end
`endif

package fifo_pkg;

  localparam int FIFO_MIN_DEPTH = 2;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the occupancy can represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sdp_ram.sv
`default_nettype none
// =============================================================================
// fifo_sdp_ram : simple dual-port WIDTH x DEPTH RAM, synchronous write,
//                registered read with read-enable. Rev 1.0
// =============================================================================
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    re,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// =============================================================================
// fifo_sync_param : single-clock FIFO with threshold flags, sticky errors and
//                   rd_valid. Define FIFO_HWM_EN to add the buf_hwm output.
// Rev 1.0
// =============================================================================
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = 56,
  parameter int AE_LEVEL = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        buf_in,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        buf_out,
  output logic                    rd_valid,
  output logic                    buf_empty,
  output logic                    buf_full,
  output logic                    buf_almost_empty,
  output logic                    buf_almost_full,
  output logic                    overflow,
  output logic                    underflow,
`ifdef FIFO_HWM_EN
  output logic [cnt_w(DEPTH)-1:0] buf_hwm,
`endif
  output logic [cnt_w(DEPTH)-1:0] fifo_counter
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  `FIFO_PARAM_CHECK(DEPTH, AF_LEVEL, AE_LEVEL)

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc;
  logic             rd_acc;

  assign buf_empty        = (count_q == '0);
  assign buf_full         = (count_q == CNT_W'(DEPTH));
  assign buf_almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign buf_almost_full  = (count_q >= CNT_W'(AF_LEVEL));

  assign wr_acc = wr_en & ~buf_full;
  assign rd_acc = rd_en & ~buf_empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Set takes priority over a same-cycle clear.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en & buf_full)  overflow_d  = 1'b1;
    if (rd_en & buf_empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (buf_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (buf_out)
  );

  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign fifo_counter = count_q;

`ifdef FIFO_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;
  logic [CNT_W-1:0] hwm_base;

  // A clear restarts tracking from the count being loaded this edge.
  always_comb begin
    hwm_base = err_clr ? '0 : hwm_q;
    hwm_d    = (count_d > hwm_base) ? count_d : hwm_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign buf_hwm = hwm_q;
`endif

endmodule

`default_nettype wire
